// File: rtl/ternary_matvec_stream.sv
// Streaming ternary-weight matrix-vector engine: accumulates COMPUTE_SLICES dot products per vector,
// then scales, saturates and double-buffers the results so one vector drains while the next accumulates.
module ternary_matvec_stream #(
   parameter int COMPUTE_SLICES = 4,
   parameter int VECTOR_LEN     = 16,
   parameter int IN_WIDTH       = 8,
   parameter int OUT_WIDTH      = 8,
   parameter int SHIFT          = 0
) (
   input  logic                                i_clk,
   input  logic                                i_rst,
   input  logic                                i_clear,
   input  logic                                i_in_valid,
   output logic                                o_in_ready,
   input  logic signed [IN_WIDTH-1:0]          i_in_act,
   input  logic        [2*COMPUTE_SLICES-1:0]  i_in_weights,
   output logic                                o_out_valid,
   input  logic                                i_out_ready,
   output logic signed [OUT_WIDTH-1:0]         o_out_data,
   output logic                                o_out_last
);

   localparam int ACC_WIDTH = IN_WIDTH + $clog2(VECTOR_LEN) + 1;
   localparam int KW        = $clog2(VECTOR_LEN);
   localparam int IW        = (COMPUTE_SLICES > 1) ? $clog2(COMPUTE_SLICES) : 1;
   localparam int CW        = (ACC_WIDTH > OUT_WIDTH) ? ACC_WIDTH : OUT_WIDTH;

   localparam logic [KW-1:0]        LAST_K   = KW'(VECTOR_LEN - 1);
   localparam logic [IW-1:0]        LAST_IDX = IW'(COMPUTE_SLICES - 1);
   localparam logic signed [CW-1:0] SAT_MAX  = CW'((2 ** (OUT_WIDTH - 1)) - 1);
   localparam logic signed [CW-1:0] SAT_MIN  = CW'(-(2 ** (OUT_WIDTH - 1)));

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_DRAIN = 1'b1
   } state_t;

   state_t                       r_state;
   state_t                       w_stateNext;
   logic [KW-1:0]                r_kCnt;
   logic signed [ACC_WIDTH-1:0]  r_acc      [COMPUTE_SLICES];
   logic signed [ACC_WIDTH-1:0]  w_finalSum [COMPUTE_SLICES];
   logic signed [ACC_WIDTH-1:0]  w_shifted  [COMPUTE_SLICES];
   logic signed [CW-1:0]         w_wide     [COMPUTE_SLICES];
   logic signed [OUT_WIDTH-1:0]  w_sat      [COMPUTE_SLICES];
   logic signed [OUT_WIDTH-1:0]  r_outBuf   [COMPUTE_SLICES];
   logic [IW-1:0]                r_outIdx;
   logic signed [OUT_WIDTH-1:0]  r_outData;
   logic                         r_outLast;
   logic signed [ACC_WIDTH-1:0]  w_actExt;
   logic                         w_accept;
   logic                         w_lastBeat;
   logic                         w_outFire;

   // The closing beat of a vector may only enter once the previous result has left or is leaving now.
   assign o_in_ready = !i_rst && !((r_kCnt == LAST_K) && (r_state == S_DRAIN) && !(i_out_ready && r_outLast));
   assign w_accept   = i_in_valid && o_in_ready && !i_clear;
   assign w_lastBeat = w_accept && (r_kCnt == LAST_K);
   assign w_outFire  = (r_state == S_DRAIN) && i_out_ready;
   assign w_actExt   = ACC_WIDTH'(i_in_act);

   assign o_out_valid = (r_state == S_DRAIN);
   assign o_out_data  = r_outData;
   assign o_out_last  = r_outLast;

   // Per-slice sum including the current beat, then scale and clamp to the output range.
   always_comb begin
      for (int j = 0; j < COMPUTE_SLICES; j++) begin
         case (i_in_weights[2*j +: 2])
            2'b01:   w_finalSum[j] = r_acc[j] + w_actExt;
            2'b11:   w_finalSum[j] = r_acc[j] - w_actExt;
            default: w_finalSum[j] = r_acc[j];
         endcase
         w_shifted[j] = w_finalSum[j] >>> SHIFT;
         w_wide[j]    = CW'(w_shifted[j]);
         if (w_wide[j] > SAT_MAX) begin
            w_sat[j] = SAT_MAX[OUT_WIDTH-1:0];
         end else if (w_wide[j] < SAT_MIN) begin
            w_sat[j] = SAT_MIN[OUT_WIDTH-1:0];
         end else begin
            w_sat[j] = w_wide[j][OUT_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_kCnt <= '0;
         for (int j = 0; j < COMPUTE_SLICES; j++) r_acc[j] <= '0;
      end else if (i_clear) begin
         r_kCnt <= '0;
         for (int j = 0; j < COMPUTE_SLICES; j++) r_acc[j] <= '0;
      end else if (w_accept) begin
         if (w_lastBeat) begin
            r_kCnt <= '0;
            for (int j = 0; j < COMPUTE_SLICES; j++) r_acc[j] <= '0;
         end else begin
            r_kCnt <= r_kCnt + KW'(1);
            for (int j = 0; j < COMPUTE_SLICES; j++) r_acc[j] <= w_finalSum[j];
         end
      end
   end

   // A completing vector reloads the drain even on the edge that retires the previous last slice.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         S_IDLE:  if (w_lastBeat) w_stateNext = S_DRAIN;
         S_DRAIN: if (w_outFire && r_outLast && !w_lastBeat) w_stateNext = S_IDLE;
         default: w_stateNext = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_outIdx  <= '0;
         r_outData <= '0;
         r_outLast <= 1'b0;
         for (int j = 0; j < COMPUTE_SLICES; j++) r_outBuf[j] <= '0;
      end else begin
         r_state <= w_stateNext;
         if (w_lastBeat) begin
            for (int j = 0; j < COMPUTE_SLICES; j++) r_outBuf[j] <= w_sat[j];
            r_outIdx  <= '0;
            r_outData <= w_sat[0];
            r_outLast <= (COMPUTE_SLICES == 1);
         end else if (w_outFire) begin
            if (r_outLast) begin
               r_outIdx  <= '0;
               r_outLast <= 1'b0;
            end else begin
               r_outIdx  <= r_outIdx + IW'(1);
               r_outData <= r_outBuf[r_outIdx + IW'(1)];
               r_outLast <= ((r_outIdx + IW'(1)) == LAST_IDX);
            end
         end
      end
   end

endmodule

// File: tb/tb_ternary_matvec_stream.sv
// Directed bench for ternary_matvec_stream: a table of whole vectors plus hand-written
// back-pressure, clear and reset sequences; a SHIFT=4 twin shares every input.
module tb_ternary_matvec_stream;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              clear = 1'b0;
   logic              inValid = 1'b0;
   logic              inReady;
   logic              inReadyS;
   logic signed [7:0] inAct = '0;
   logic        [7:0] inWeights = '0;
   logic              outValid;
   logic              outValidS;
   logic              outReady = 1'b0;
   logic signed [7:0] outData;
   logic signed [7:0] outDataS;
   logic              outLast;
   logic              outLastS;

   int checks = 0;
   int failures = 0;
   int gotData[$];
   int gotLast[$];
   int gotS[$];
   bit inAccepted;

   typedef struct packed {
      int         actBase;
      int         actStep;
      logic [7:0] weights;
      int         e0, e1, e2, e3;
      int         s0, s1, s2, s3;
   } vec_t;

   ternary_matvec_stream #(.COMPUTE_SLICES(4), .VECTOR_LEN(16), .IN_WIDTH(8), .OUT_WIDTH(8), .SHIFT(0)) dut (
      .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_in_valid(inValid), .o_in_ready(inReady),
      .i_in_act(inAct), .i_in_weights(inWeights), .o_out_valid(outValid), .i_out_ready(outReady),
      .o_out_data(outData), .o_out_last(outLast)
   );

   ternary_matvec_stream #(.COMPUTE_SLICES(4), .VECTOR_LEN(16), .IN_WIDTH(8), .OUT_WIDTH(8), .SHIFT(4)) dutShift (
      .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_in_valid(inValid), .o_in_ready(inReadyS),
      .i_in_act(inAct), .i_in_weights(inWeights), .o_out_valid(outValidS), .i_out_ready(outReady),
      .o_out_data(outDataS), .o_out_last(outLastS)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Inputs are set at a falling edge; handshakes are recorded 1ns later, before the rising edge.
   task automatic cycle();
      #1;
      inAccepted = inValid && inReady && !clear;
      if (!rst && outValid && outReady) begin
         gotData.push_back(int'(outData));
         gotLast.push_back(int'(outLast));
      end
      if (!rst && outValidS && outReady) gotS.push_back(int'(outDataS));
      @(negedge clk);
   endtask

   // Present one column beat and hold it until it is accepted, within a bounded wait.
   task automatic applyStimulus(input int act, input logic [7:0] w);
      int n;
      n = 0;
      inValid   = 1'b1;
      inAct     = 8'(act);
      inWeights = w;
      do begin
         cycle();
         n++;
      end while (!inAccepted && n < 40);
      if (!inAccepted) checkOutput("inAcceptTimeout", 0, 1);
      inValid = 1'b0;
   endtask

   task automatic sendVector(input int base, input int step, input logic [7:0] w);
      for (int k = 0; k < 16; k++) applyStimulus(base + step * k, w);
   endtask

   task automatic drainCollect(input int n);
      int budget;
      budget = 0;
      while (gotData.size() < n && budget < 40) begin
         cycle();
         budget++;
      end
      checkOutput("drainCount", gotData.size(), n);
   endtask

   task automatic compareResults(input string tag, input int exp[$], input int expS[$]);
      for (int i = 0; i < exp.size(); i++) begin
         if (i < gotData.size()) begin
            checkOutput($sformatf("%s data[%0d]", tag, i), gotData[i], exp[i]);
            checkOutput($sformatf("%s last[%0d]", tag, i), gotLast[i], ((i % 4) == 3) ? 1 : 0);
         end
         if (i < gotS.size()) begin
            checkOutput($sformatf("%s shiftData[%0d]", tag, i), gotS[i], expS[i]);
         end else begin
            checkOutput($sformatf("%s shiftCount", tag), gotS.size(), expS.size());
         end
      end
   endtask

   task automatic clearQueues();
      gotData.delete();
      gotLast.delete();
      gotS.delete();
   endtask

   initial begin
      vec_t vecs[5];
      int   e[$];
      int   es[$];

      vecs[0] = '{1,    0, 8'h55,  16,   16,  16,  16,   1,  1,  1,  1};
      vecs[1] = '{0,    1, 8'h8D,  120, -120, 0,   0,    7, -8,  0,  0};
      vecs[2] = '{127,  0, 8'h55,  127,  127, 127, 127,  127, 127, 127, 127};
      vecs[3] = '{-128, 0, 8'h55, -128, -128, -128, -128, -128, -128, -128, -128};
      vecs[4] = '{-3,   1, 8'h67, -72,   72,  0,   72,  -5,  4,  0,  4};

      @(negedge clk);
      #1;
      checkOutput("resetInReady", int'(inReady), 0);
      checkOutput("resetOutValid", int'(outValid), 0);
      checkOutput("resetOutData", int'(outData), 0);
      checkOutput("resetOutLast", int'(outLast), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("inReadyAfterRelease", int'(inReady), 1);
      @(negedge clk);

      outReady = 1'b1;
      for (int i = 0; i < 5; i++) begin
         clearQueues();
         for (int k = 0; k < 15; k++) applyStimulus(vecs[i].actBase + vecs[i].actStep * k, vecs[i].weights);
         checkOutput($sformatf("vec%0d validBeforeLast", i), int'(outValid), 0);
         applyStimulus(vecs[i].actBase + vecs[i].actStep * 15, vecs[i].weights);
         checkOutput($sformatf("vec%0d latencyValid", i), int'(outValid), 1);
         checkOutput($sformatf("vec%0d firstData", i), int'(outData), vecs[i].e0);
         drainCollect(4);
         e  = {vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3};
         es = {vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3};
         compareResults($sformatf("vec%0d", i), e, es);
      end

      // Back-pressure: second vector's closing beat waits for the first result's last handshake.
      clearQueues();
      outReady = 1'b0;
      sendVector(1, 0, 8'h55);
      for (int k = 0; k < 15; k++) applyStimulus(2, 8'h55);
      inValid   = 1'b1;
      inAct     = 8'sd2;
      inWeights = 8'h55;
      for (int c = 0; c < 3; c++) begin
         cycle();
         checkOutput($sformatf("stallInReady[%0d]", c), int'(inAccepted), 0);
         checkOutput($sformatf("holdData[%0d]", c), int'(outData), 16);
      end
      outReady = 1'b1;
      for (int c = 0; c < 4; c++) begin
         cycle();
         checkOutput($sformatf("finalBeatAccept[%0d]", c), int'(inAccepted), (c == 3) ? 1 : 0);
      end
      inValid = 1'b0;
      checkOutput("noGapValid", int'(outValid), 1);
      checkOutput("noGapData", int'(outData), 32);
      drainCollect(8);
      compareResults("backPressure", {16, 16, 16, 16, 32, 32, 32, 32}, {1, 1, 1, 1, 2, 2, 2, 2});

      // Clear discards a partial vector and the beat presented alongside it.
      clearQueues();
      for (int k = 0; k < 5; k++) applyStimulus(50, 8'h55);
      clear     = 1'b1;
      inValid   = 1'b1;
      inAct     = 8'sd50;
      inWeights = 8'h55;
      cycle();
      clear   = 1'b0;
      inValid = 1'b0;
      checkOutput("clearNoValid", int'(outValid), 0);
      sendVector(1, 0, 8'h55);
      drainCollect(4);
      compareResults("clear", {16, 16, 16, 16}, {1, 1, 1, 1});

      // Reset in the middle of accumulation.
      clearQueues();
      for (int k = 0; k < 8; k++) applyStimulus(1, 8'h55);
      rst = 1'b1;
      #1;
      checkOutput("midVecResetValid", int'(outValid), 0);
      checkOutput("midVecResetInReady", int'(inReady), 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      sendVector(3, 0, 8'h55);
      drainCollect(4);
      compareResults("midVecReset", {48, 48, 48, 48}, {3, 3, 3, 3});

      // Reset in the middle of draining.
      clearQueues();
      outReady = 1'b0;
      sendVector(1, 0, 8'h55);
      outReady = 1'b1;
      cycle();
      outReady = 1'b0;
      rst = 1'b1;
      #1;
      checkOutput("midDrainResetValid", int'(outValid), 0);
      @(negedge clk);
      rst      = 1'b0;
      outReady = 1'b1;
      clearQueues();
      repeat (6) cycle();
      checkOutput("noStaleOutput", gotData.size(), 0);
      sendVector(-2, 0, 8'hFF);
      drainCollect(4);
      compareResults("afterDrainReset", {32, 32, 32, 32}, {2, 2, 2, 2});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard bound on total run time.
   initial begin
      #200000;
      failures++;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ternary_matvec_stream.md
# ternary_matvec_stream

Streaming 1.58-bit (ternary-weight) matrix-vector engine, the parametrised successor of the fixed-slice compute core inside `tt_um_rejunity_1_58bit`. It computes COMPUTE_SLICES dot products in parallel, y[j] = sum over k of W[j][k]·x[k] for k = 0..VECTOR_LEN-1, with signed activations and ternary weights. Activation/weight columns arrive over a valid/ready stream. Results are scaled, saturated and double-buffered, then streamed out one slice per beat, so the next vector accumulates while the previous one drains.

## Interface
- COMPUTE_SLICES, 4: parallel output rows (accumulators); ≥1.
- VECTOR_LEN, 16: beats (columns) per vector; ≥2.
- IN_WIDTH, 8: signed activation width.
- OUT_WIDTH, 8: signed result width after scaling.
- SHIFT, 0: arithmetic right shift applied before saturation.
- ACC_WIDTH (localparam) = IN_WIDTH + clog2(VECTOR_LEN) + 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous and active-high.
- clear  in  1  synchronous abort of the partial accumulation.
- in_valid  in  1  column beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_act  in  IN_WIDTH  signed activation x[k].
- in_weights  in  2*COMPUTE_SLICES  ternary W[j][k] at bits [2j+1:2j]: 00=0, 01=+1, 11=-1, 10=reserved (treated as 0).
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer ready.
- out_data  out  OUT_WIDTH  signed result for the current slice.
- out_last  out  1  high on the beat for slice COMPUTE_SLICES-1.

## Operation
- Column counter k_cnt runs 0..VECTOR_LEN-1; accumulators acc[j] are ACC_WIDTH signed.
- On an accepted beat, acc[j] += +x, -x or 0 per weight code. Sign-extend x to ACC_WIDTH first. No overflow is possible.
- Accepted beat with k_cnt < VECTOR_LEN-1: k_cnt increments.
- Accepted beat with k_cnt == VECTOR_LEN-1, in the same edge:
  - out_buf[j] <= sat(final_sum[j] >>> SHIFT), where final_sum includes this beat.
  - acc cleared, k_cnt <= 0, out_valid <= 1, out_idx <= 0.
- sat clamps to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
- Output FSM, two states:
  - IDLE (out_valid=0).
  - DRAIN (out_valid=1): out_data = out_buf[out_idx]; out_last = (out_idx == COMPUTE_SLICES-1).
  - out_valid && out_ready: out_idx increments. On out_last the FSM returns to IDLE, unless a new vector completes in the same edge; then it reloads and stays in DRAIN with out_idx=0.
- in_ready = !reset && !(k_cnt == VECTOR_LEN-1 && out_valid && !(out_ready && out_last)). The final beat of a vector stalls only while the previous result is still draining and not finishing this cycle.
- clear: acc <= 0 and k_cnt <= 0; any same-cycle input beat is discarded. The output buffer and FSM are unaffected.
- Slices are emitted in order 0..COMPUTE_SLICES-1. Once out_valid is high, out_data and out_idx stay stable until the handshake.

## Timing
- Reset values: in_ready 0 while reset is high, 1 from the first cycle after release. out_valid 0, out_data 0, out_last 0, acc 0, k_cnt 0, out_idx 0.
- Latency: out_valid rises on the edge that accepts beat VECTOR_LEN-1. It is visible the cycle after that beat's handshake.
- Full throughput: one input beat per cycle and one output beat per cycle. Sustained vector rate is limited by max(VECTOR_LEN, COMPUTE_SLICES) cycles.
- Reset mid-operation discards the partial vector and any undrained results. No output beat is emitted after reset.
- in_valid low holds all state. out_ready low holds out_data/out_idx.
- Registered outputs: out_valid, out_data, out_last. in_ready is combinational from registered state, reset and out_ready only; it has no path from in_valid.

## Test plan
Configuration: COMPUTE_SLICES=4, VECTOR_LEN=16, IN_WIDTH=8, OUT_WIDTH=8, SHIFT=0 unless stated.
- All weights 01, x=1 for 16 beats, out_ready=1 -> outputs 16,16,16,16, out_last on beat 4, out_valid first seen 1 cycle after beat 16.
- Weights per slice 01, 11, 00, 10; x=k for k=0..15 -> 120, -120, 0, 0.
- Saturation:
  - x=127 all 01 -> 127 each.
  - x=-128 all 01 -> -128.
  - SHIFT=4 with x=127 all 01 -> 127 (2032>>>4).
- Back-pressure:
  - Hold out_ready=0 and send two vectors back to back -> in_ready low on beat 16 of vector 2 until vector 1's out_last handshake.
  - Both result sets are correct and in order.
  - The simultaneous last-out/last-in edge keeps DRAIN with no gap.
- clear after 5 beats of x=50, then a full vector of x=1 all 01 -> outputs 16 each. A beat presented together with clear is ignored.
- Assert reset mid-vector (beat 8) and mid-drain -> out_valid drops immediately, no stale output afterwards, next full vector gives correct sums.
